// File: rtl/vx_sau_array_ctrl.sv
// vx_sau_array_ctrl
// Controller and N x N output-stationary systolic array computing C = A*B
// or C += A*B on square operand matrices.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_*      operation request handshake (accumulate / signed mode sampled here)
//   ld_*       2N load beats: A rows 0..N-1, then B columns 0..N-1
//   rsp_*      N result rows, row r = accumulator row r, rsp_last on row N-1
//   busy       high whenever the controller is not idle
module vx_sau_array_ctrl #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_SIZE   = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_accum,
  input  logic                             req_signed,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] ld_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [MATRIX_SIZE*ACC_WIDTH-1:0] rsp_data,
  output logic                             rsp_last,
  output logic                             busy
);

  localparam int N  = MATRIX_SIZE;
  localparam int W  = DATA_SIZE;
  localparam int PW = 2 * DATA_SIZE;
  localparam int CW = $clog2(3 * N);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(3 * N - 2);
  localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

  if (ACC_WIDTH < 2 * DATA_SIZE) begin : g_bad_acc_width
    $error("ACC_WIDTH must be at least 2*DATA_SIZE");
  end
  if (MATRIX_SIZE < 2 || MATRIX_SIZE > 16) begin : g_bad_matrix_size
    $error("MATRIX_SIZE must lie in 2..16");
  end

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  // Full-width product of one a/b pair, extended to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [W-1:0] a,
                                                    input logic [W-1:0] b,
                                                    input logic         sgn);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = PW'($signed(a)) * PW'($signed(b));
    pu = PW'(a) * PW'(b);
    if (sgn) return ACC_WIDTH'(ps);
    else     return ACC_WIDTH'(pu);
  endfunction

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   sgn_q, sgn_d;
  logic                   req_ready_q, req_ready_d;
  logic                   ld_ready_q, ld_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_last_q, rsp_last_d;
  logic                   busy_q, busy_d;
  logic [W-1:0]           a_q [N][N];
  logic [W-1:0]           a_d [N][N];
  logic [W-1:0]           b_q [N][N];
  logic [W-1:0]           b_d [N][N];
  logic [ACC_WIDTH-1:0]   acc_q [N][N];
  logic [ACC_WIDTH-1:0]   acc_d [N][N];
  logic [W-1:0]           a_mem [N][N];  // a_mem[i][k] = A[i][k]
  logic [W-1:0]           b_mem [N][N];  // b_mem[k][j] = B[k][j]
  logic [W-1:0]           edge_a [N];
  logic [W-1:0]           edge_b [N];
  logic                   ld_fire;
  logic                   ld_is_a;
  logic [RW-1:0]          ld_idx;

  assign ld_fire = (state_q == LOAD) && ld_valid;
  assign ld_is_a = cnt_q < CW'(N);
  assign ld_idx  = ld_is_a ? RW'(cnt_q) : RW'(cnt_q - CW'(N));

  // Operand storage: beats 0..N-1 fill A rows, beats N..2N-1 fill B columns.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      for (int k = 0; k < N; k++) begin
        if (ld_is_a) a_mem[ld_idx][k] <= ld_data[k*W +: W];
        else         b_mem[k][ld_idx] <= ld_data[k*W +: W];
      end
    end
  end

  // Skewed array edges: row i sees A[i][c-i], column j sees B[c-j][j].
  always_comb begin
    int idx;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      edge_a[i] = '0;
      edge_b[i] = '0;
    end
    if (state_q == COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        idx = int'(cnt_q) - i;
        if (idx >= 0 && idx < N) begin
          edge_a[i] = a_mem[i][RW'(idx)];
          edge_b[i] = b_mem[RW'(idx)][i];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    sgn_d       = sgn_q;
    rsp_valid_d = rsp_valid_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_d[i][j]   = '0;
        b_d[i][j]   = '0;
        acc_d[i][j] = acc_q[i][j];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = LOAD;
          cnt_d   = '0;
          row_d   = '0;
          sgn_d   = req_signed;
          if (!req_accum) begin
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++) acc_d[i][j] = '0;
          end
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = COMPUTE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        // PE stage: operands move one PE right/down per cycle; each PE
        // accumulates the product of its registered operands.
        for (int i = 0; i < N; i++) begin
          a_d[i][0] = edge_a[i];
          b_d[0][i] = edge_b[i];
          for (int j = 1; j < N; j++) begin
            a_d[i][j] = a_q[i][j-1];
            b_d[j][i] = b_q[j-1][i];
          end
        end
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc_d[i][j] = acc_q[i][j] + ext_prod(a_q[i][j], b_q[i][j], sgn_q);
        if (cnt_q == LAST_CYC) begin
          state_d     = DRAIN;
          cnt_d       = '0;
          row_d       = '0;
          rsp_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // First DRAIN cycle only raises rsp_valid; rows then advance per handshake.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          if (row_q == LAST_ROW) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            row_d       = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    ld_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    rsp_last_d  = rsp_valid_d && (row_d == LAST_ROW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      sgn_q       <= 1'b0;
      req_ready_q <= 1'b1;
      ld_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      sgn_q       <= sgn_d;
      req_ready_q <= req_ready_d;
      ld_ready_q  <= ld_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
    end
  end

  always_comb begin
    rsp_data = '0;
    for (int j = 0; j < N; j++) rsp_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
  end

  assign req_ready = req_ready_q;
  assign ld_ready  = ld_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vx_sau_array_ctrl.sv
// Testbench for vx_sau_array_ctrl with N=3, W=8, ACC_WIDTH=32.
module tb_vx_sau_array_ctrl;
  localparam int N   = 3;
  localparam int W   = 8;
  localparam int AW  = 32;
  localparam int LDW = N * W;

  typedef logic [W-1:0]  mat8_t  [N][N];
  typedef logic [AW-1:0] mat32_t [N][N];

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           req_valid = 1'b0, req_accum = 1'b0, req_signed = 1'b0;
  logic           ld_valid = 1'b0, rsp_ready = 1'b0;
  logic [LDW-1:0] ld_data = '0;
  logic           req_ready, ld_ready, rsp_valid, rsp_last, busy;
  logic [N*AW-1:0] rsp_data;

  int checks = 0;
  int errors = 0;
  mat32_t model_c;

  always #5 clk = ~clk;

  vx_sau_array_ctrl #(.MATRIX_SIZE(N), .DATA_SIZE(W), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_accum(req_accum), .req_signed(req_signed),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: C = sum_k A[i][k]*B[k][j] (plus prior C when accumulating), mod 2^32.
  task automatic model_op(input mat8_t a, input mat8_t b, input bit accum, input bit sgn);
    logic [AW-1:0] s;
    int p;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = accum ? model_c[i][j] : '0;
        for (int k = 0; k < N; k++) begin
          if (sgn) p = int'($signed(a[i][k])) * int'($signed(b[k][j]));
          else     p = int'(a[i][k]) * int'(b[k][j]);
          s = s + AW'(p);
        end
        model_c[i][j] = s;
      end
    end
  endtask

  task automatic rand_mat(output mat8_t m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m[i][j] = W'($urandom);
  endtask

  task automatic start_op(input mat8_t a, input mat8_t b, input bit accum, input bit sgn,
                          input bit gaps, output bit to);
    int t;
    to = 0;
    t = 0;
    while (!req_ready && t < 100) begin step; t++; end
    if (!req_ready) to = 1;
    req_valid = 1; req_accum = accum; req_signed = sgn;
    step;
    req_valid = 0; req_accum = 0; req_signed = 0;
    for (int beat = 0; beat < 2 * N; beat++) begin
      if (gaps && $urandom_range(3) == 0) begin ld_valid = 0; step; end
      ld_data = '0;
      for (int k = 0; k < N; k++) begin
        if (beat < N) ld_data[k*W +: W] = a[beat][k];
        else          ld_data[k*W +: W] = b[k][beat-N];
      end
      ld_valid = 1;
      if (!ld_ready) to = 1;
      step;
    end
    ld_valid = 0;
  endtask

  task automatic drain_op(input int stall_pct, input bit noise, output mat32_t got,
                          output bit [N-1:0] lastv, output int lat, output bit to, output bit ldr);
    int t;
    int s;
    to = 0; ldr = 0; t = 0;
    while (!rsp_valid && t < 100) begin step; t++; end
    lat = t;
    if (!rsp_valid) to = 1;
    for (int r = 0; r < N; r++) begin
      s = 0;
      rsp_ready = 0;
      while (s < 4 && $urandom_range(99) < stall_pct) begin
        if (noise) begin ld_valid = 1; ld_data = LDW'($urandom); end
        step; s++;
        if (ld_ready) ldr = 1;
      end
      if (!rsp_valid) to = 1;
      for (int j = 0; j < N; j++) got[r][j] = rsp_data[j*AW +: AW];
      lastv[r] = rsp_last;
      rsp_ready = 1;
      step;
      rsp_ready = 0;
      if (ld_ready) ldr = 1;
    end
    ld_valid = 0;
  endtask

  task automatic ident_mats(output mat8_t a, output mat8_t b);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = (i == j) ? 8'd1 : 8'd0;
        b[i][j] = W'(i * N + j + 1);
      end
  endtask

  task automatic test_reset;
    #3 reset_n = 0;
    #1;
    checks++;
    if ({req_ready, ld_ready, rsp_valid, rsp_last, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_outputs got rdy/ld/vld/last/busy=%b want 10000",
               {req_ready, ld_ready, rsp_valid, rsp_last, busy});
    end
    checks++;
    if (rsp_data !== '0) begin
      errors++; $display("FAIL reset_data got %h want 0", rsp_data);
    end
    step; step;
    reset_n = 1;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) model_c[i][j] = '0;
    step; step;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_identity;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr;
    ident_mats(a, b);
    model_op(a, b, 0, 0);
    start_op(a, b, 0, 0, 0, to);
    drain_op(0, 0, got, lastv, lat, to2, ldr);
    checks++;
    if (to || to2) begin errors++; $display("FAIL ident_timeout got %b%b want 00", to, to2); end
    checks++;
    if (lat !== 3 * N) begin errors++; $display("FAIL ident_latency got %0d want %0d", lat, 3 * N); end
    checks++;
    if (lastv !== 3'b100) begin errors++; $display("FAIL ident_last got %b want 100", lastv); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (got[i][j] !== model_c[i][j] || got[i][j] !== AW'(i * N + j + 1)) begin
          errors++;
          $display("FAIL ident_c%0d%0d got %0d want %0d", i, j, got[i][j], i * N + j + 1);
        end
      end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL ident_idle got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_accum;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr;
    ident_mats(a, b);
    model_op(a, b, 1, 0);
    start_op(a, b, 1, 0, 0, to);
    drain_op(0, 0, got, lastv, lat, to2, ldr);
    checks++;
    if (to || to2) begin errors++; $display("FAIL accum_timeout got %b%b want 00", to, to2); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (got[i][j] !== model_c[i][j] || got[i][j] !== AW'(2 * (i * N + j + 1))) begin
          errors++;
          $display("FAIL accum_c%0d%0d got %0d want %0d", i, j, got[i][j], 2 * (i * N + j + 1));
        end
      end
  endtask

  task automatic test_signed;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr;
    logic [AW-1:0] want;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin a[i][j] = 8'hFF; b[i][j] = 8'h02; end
    for (int mode = 1; mode >= 0; mode--) begin
      want = (mode == 1) ? 32'hFFFF_FFFA : 32'd1530;
      model_op(a, b, 0, mode[0]);
      start_op(a, b, 0, mode[0], 0, to);
      drain_op(20, 0, got, lastv, lat, to2, ldr);
      checks++;
      if (to || to2) begin errors++; $display("FAIL signed%0d_timeout got %b%b want 00", mode, to, to2); end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          checks++;
          if (got[i][j] !== model_c[i][j] || got[i][j] !== want) begin
            errors++;
            $display("FAIL signed%0d_c%0d%0d got %h want %h", mode, i, j, got[i][j], want);
          end
        end
    end
  endtask

  task automatic test_backpressure;
    mat8_t a, b; bit to; int t;
    logic [N*AW-1:0] row1;
    rand_mat(a); rand_mat(b);
    model_op(a, b, 0, 1);
    for (int j = 0; j < N; j++) row1[j*AW +: AW] = model_c[1][j];
    start_op(a, b, 0, 1, 0, to);
    t = 0;
    while (!rsp_valid && t < 100) begin step; t++; end
    checks++;
    if (to || !rsp_valid) begin errors++; $display("FAIL bp_start got to=%b vld=%b want 0 1", to, rsp_valid); end
    rsp_ready = 1; step; rsp_ready = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = (c % 2 == 0);
      checks++;
      if (rsp_data !== row1 || rsp_last !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got data=%h last=%b busy=%b rdy=%b want data=%h last=0 busy=1 rdy=0",
                 c, rsp_data, rsp_last, busy, req_ready, row1);
      end
      step;
    end
    req_valid = 0;
    checks++;
    if (rsp_data !== row1) begin errors++; $display("FAIL bp_row1 got %h want %h", rsp_data, row1); end
    rsp_ready = 1; step; rsp_ready = 0;
    checks++;
    if (rsp_last !== 1'b1 || rsp_data[AW-1:0] !== model_c[2][0]) begin
      errors++; $display("FAIL bp_row2 got last=%b c20=%h want 1 %h", rsp_last, rsp_data[AW-1:0], model_c[2][0]);
    end
    rsp_ready = 1; step; rsp_ready = 0;
    step; step; step;
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_not_queued got busy=%b rdy=%b want 0 1", busy, req_ready);
    end
  endtask

  task automatic test_ld_ignored;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr;
    ld_valid = 1; ld_data = LDW'($urandom);
    step; step; step;
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL ldign_idle got ldrdy=%b busy=%b rdy=%b want 0 0 1", ld_ready, busy, req_ready);
    end
    ld_valid = 0;
    rand_mat(a); rand_mat(b);
    model_op(a, b, 0, 0);
    start_op(a, b, 0, 0, 0, to);
    drain_op(60, 1, got, lastv, lat, to2, ldr);
    checks++;
    if (to || to2 || ldr) begin errors++; $display("FAIL ldign_drain got to=%b%b ldrdy_seen=%b want 00 0", to, to2, ldr); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (got[i][j] !== model_c[i][j]) begin
          errors++; $display("FAIL ldign_c%0d%0d got %h want %h", i, j, got[i][j], model_c[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr; bit saw_vld;
    rand_mat(a); rand_mat(b);
    start_op(a, b, 1, 1, 0, to);
    step; step; step; step;
    #2 reset_n = 0;
    #1;
    checks++;
    if ({req_ready, ld_ready, rsp_valid, rsp_last, busy} !== 5'b10000 || rsp_data !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got rdy/ld/vld/last/busy=%b data=%h want 10000 0",
               {req_ready, ld_ready, rsp_valid, rsp_last, busy}, rsp_data);
    end
    saw_vld = 0;
    for (int c = 0; c < 3; c++) begin step; if (rsp_valid) saw_vld = 1; end
    reset_n = 1;
    for (int c = 0; c < 3; c++) begin step; if (rsp_valid) saw_vld = 1; end
    checks++;
    if (saw_vld || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got vld_seen=%b busy=%b want 0 0", saw_vld, busy); end
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) model_c[i][j] = '0;
    rand_mat(a); rand_mat(b);
    model_op(a, b, 1, 0);
    start_op(a, b, 1, 0, 0, to);
    drain_op(0, 0, got, lastv, lat, to2, ldr);
    checks++;
    if (to || to2 || lat !== 3 * N) begin errors++; $display("FAIL rstmid_op got to=%b%b lat=%0d want 00 %0d", to, to2, lat, 3 * N); end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (got[i][j] !== model_c[i][j]) begin
          errors++; $display("FAIL rstmid_c%0d%0d got %h want %h", i, j, got[i][j], model_c[i][j]);
        end
      end
  endtask

  task automatic test_random;
    mat8_t a, b; mat32_t got; bit [N-1:0] lastv; int lat; bit to, to2, ldr; bit accum, sgn;
    for (int op = 0; op < 6; op++) begin
      rand_mat(a); rand_mat(b);
      accum = 1'($urandom_range(1));
      sgn   = 1'($urandom_range(1));
      model_op(a, b, accum, sgn);
      start_op(a, b, accum, sgn, 1, to);
      drain_op(40, 1, got, lastv, lat, to2, ldr);
      checks++;
      if (to || to2 || ldr || lat !== 3 * N || lastv !== 3'b100) begin
        errors++;
        $display("FAIL rand%0d_ctrl got to=%b%b ldr=%b lat=%0d last=%b want 00 0 %0d 100",
                 op, to, to2, ldr, lat, lastv, 3 * N);
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          checks++;
          if (got[i][j] !== model_c[i][j]) begin
            errors++; $display("FAIL rand%0d_c%0d%0d got %h want %h", op, i, j, got[i][j], model_c[i][j]);
          end
        end
    end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_accum;
    test_signed;
    test_backpressure;
    test_ld_ignored;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
